bcd_time_keeper: RTL and testbench

Timekeeping core that produces the packed-BCD time and alarm values consumed by `DisplayControl`. It divides the system clock `CP1` to a one-second tick, keeps 24-hour time in packed BCD, and holds the alarm setpoint. It also handles the set-time and set-alarm button protocol and raises alarm and hourly-chime indications. It sits between the board buttons and the display block; its `Hour`, `Minutes`, `Second`, `AHour` and `AMinutes` outputs connect one-to-one to the display inputs of the same names.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/bcd_mod_counter.sv | 44 ++++
 rtl/bcd_time_keeper.sv | 142 ++++++++++++++
 tb/tb_bcd_time_keeper.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and BCD helper for the timekeeping core.
// Mode encodings, BCD limits and alarm reset setpoint.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    localparam logic [7:0] BCD_59      = 8'h59;
    localparam logic [7:0] BCD_23      = 8'h23;
    localparam logic [7:0] ALARM_RST_H = 8'h07;
    localparam logic [7:0] ALARM_RST_M = 8'h00;

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        logic [7:0] r;
        if (v >= lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Packed-BCD modulo counter with synchronous clear.
// Steps when both enable and carry-in are high; wraps past LIMIT.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] LIMIT   = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       cin_i,
    output logic [7:0] val_o,
    output logic       co_o
);

    logic [7:0] val_q;
    logic [7:0] val_d;
    logic       step;

    assign step = en_i & cin_i & ~clr_i;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = 8'h00;
        end else if (step) begin
            val_d = bcd_inc(val_q, LIMIT);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;
    assign co_o  = step & (val_q == LIMIT);

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour packed-BCD clock with alarm setpoint, button set protocol,
// alarm ring and hourly chime flags.
module bcd_time_keeper
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       CP1,
    input  logic       Reset,
    input  logic [1:0] Mode,
    input  logic       AdjHour,
    input  logic       AdjMinute,
    input  logic       AlarmEn,
    output logic [7:0] Hour,
    output logic [7:0] Minutes,
    output logic [7:0] Second,
    output logic [7:0] AHour,
    output logic [7:0] AMinutes,
    output logic       AlarmRing,
    output logic       HourChime
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    logic          set_time;
    logic          set_alarm;
    logic          running;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          sec_tick;
    logic [2:0]    hbtn_q;
    logic [2:0]    mbtn_q;
    logic          hr_edge;
    logic          min_edge;
    logic          sec_co;
    logic          min_co;
    logic          hr_co;
    logic          amin_co;
    logic          ahr_co;
    logic          ring_q;
    logic          ring_d;
    logic          chime_q;
    logic          chime_d;
    logic          unused_co;

    assign set_time  = (Mode == MODE_SET_TIME);
    assign set_alarm = (Mode == MODE_SET_ALARM);
    assign running   = ~set_time;

    always_comb begin
        pre_d = pre_q + PW'(1);
        if (set_time || pre_q == PRE_MAX) begin
            pre_d = '0;
        end
    end

    assign sec_tick = running & (pre_q == PRE_MAX);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    always_ff @(posedge CP1 or posedge Reset) begin
        if (Reset) begin
            pre_q   <= '0;
            hbtn_q  <= '0;
            mbtn_q  <= '0;
            ring_q  <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            hbtn_q  <= {hbtn_q[1:0], AdjHour};
            mbtn_q  <= {mbtn_q[1:0], AdjMinute};
            ring_q  <= ring_d;
            chime_q <= chime_d;
        end
    end

    assign hr_edge  = hbtn_q[1] & ~hbtn_q[2];
    assign min_edge = mbtn_q[1] & ~mbtn_q[2];

    bcd_mod_counter #(.LIMIT(BCD_59), .RST_VAL(8'h00)) u_sec (
        .clk_i (CP1),
        .rst_i (Reset),
        .clr_i (set_time),
        .en_i  (running),
        .cin_i (sec_tick),
        .val_o (Second),
        .co_o  (sec_co)
    );

    bcd_mod_counter #(.LIMIT(BCD_59), .RST_VAL(8'h00)) u_min (
        .clk_i (CP1),
        .rst_i (Reset),
        .clr_i (1'b0),
        .en_i  (1'b1),
        .cin_i ((running & sec_co) | (set_time & min_edge)),
        .val_o (Minutes),
        .co_o  (min_co)
    );

    // Minute wrap while setting must not ripple into the hour
    bcd_mod_counter #(.LIMIT(BCD_23), .RST_VAL(8'h00)) u_hr (
        .clk_i (CP1),
        .rst_i (Reset),
        .clr_i (1'b0),
        .en_i  (1'b1),
        .cin_i ((running & min_co) | (set_time & hr_edge)),
        .val_o (Hour),
        .co_o  (hr_co)
    );

    bcd_mod_counter #(.LIMIT(BCD_59), .RST_VAL(ALARM_RST_M)) u_amin (
        .clk_i (CP1),
        .rst_i (Reset),
        .clr_i (1'b0),
        .en_i  (set_alarm),
        .cin_i (min_edge),
        .val_o (AMinutes),
        .co_o  (amin_co)
    );

    bcd_mod_counter #(.LIMIT(BCD_23), .RST_VAL(ALARM_RST_H)) u_ahr (
        .clk_i (CP1),
        .rst_i (Reset),
        .clr_i (1'b0),
        .en_i  (set_alarm),
        .cin_i (hr_edge),
        .val_o (AHour),
        .co_o  (ahr_co)
    );

    assign unused_co = ^{hr_co, amin_co, ahr_co};

    always_comb begin
        ring_d  = AlarmEn & running
                & (Hour == AHour) & (Minutes == AMinutes);
        chime_d = running & (Minutes == 8'h00) & (Second <= 8'h04);
    end

    assign AlarmRing = ring_q;
    assign HourChime = chime_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Randomized bench with a seconds-of-day reference model.
// Outputs are compared every cycle plus fixed literal checkpoints.
module tb_bcd_time_keeper;

    localparam int T = 4;

    logic       CP1 = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] Mode = 2'd0;
    logic       AdjHour = 1'b0;
    logic       AdjMinute = 1'b0;
    logic       AlarmEn = 1'b0;
    logic [7:0] Hour, Minutes, Second, AHour, AMinutes;
    logic       AlarmRing, HourChime;

    int errors = 0;
    int checks = 0;

    int m_tod, m_ahm, m_pre;
    bit m_ring, m_chime;
    bit hh[3];
    bit mh[3];

    bcd_time_keeper #(.TICKS_PER_SEC(T)) dut (
        .CP1       (CP1),
        .Reset     (Reset),
        .Mode      (Mode),
        .AdjHour   (AdjHour),
        .AdjMinute (AdjMinute),
        .AlarmEn   (AlarmEn),
        .Hour      (Hour),
        .Minutes   (Minutes),
        .Second    (Second),
        .AHour     (AHour),
        .AMinutes  (AMinutes),
        .AlarmRing (AlarmRing),
        .HourChime (HourChime)
    );

    always #5 CP1 = ~CP1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tod = 0;
        m_ahm = 7 * 60;
        m_pre = 0;
        m_ring = 0;
        m_chime = 0;
        for (int i = 0; i < 3; i++) begin
            hh[i] = 0;
            mh[i] = 0;
        end
    endtask

    task automatic model_step();
        int h, m, s, ah, am;
        bit st, sa, eh, em, tick;
        st = (Mode == 2'd1);
        sa = (Mode == 2'd2);
        eh = hh[1] && !hh[2];
        em = mh[1] && !mh[2];
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        ah = m_ahm / 60;
        am = m_ahm % 60;
        m_ring = AlarmEn && !st && (h == ah) && (m == am);
        m_chime = !st && (m == 0) && (s <= 4);
        tick = !st && (m_pre == T - 1);
        m_pre = st ? 0 : (m_pre + 1) % T;
        if (st) begin
            if (eh) h = (h + 1) % 24;
            if (em) m = (m + 1) % 60;
            m_tod = h * 3600 + m * 60;
        end else if (tick) begin
            m_tod = (m_tod + 1) % 86400;
        end
        if (sa) begin
            if (eh) ah = (ah + 1) % 24;
            if (em) am = (am + 1) % 60;
            m_ahm = ah * 60 + am;
        end
        hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = AdjHour;
        mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = AdjMinute;
    endtask

    task automatic tick_cmp();
        @(posedge CP1);
        if (Reset) model_reset();
        else model_step();
        #1;
        chk("hour", Hour, bcd(m_tod / 3600));
        chk("min", Minutes, bcd((m_tod / 60) % 60));
        chk("sec", Second, bcd(m_tod % 60));
        chk("ahour", AHour, bcd(m_ahm / 60));
        chk("amin", AMinutes, bcd(m_ahm % 60));
        chk("ring", AlarmRing, m_ring);
        chk("chime", HourChime, m_chime);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_cmp();
    endtask

    task automatic press(input bit hr, input int hold);
        if (hr) AdjHour = 1'b1;
        else AdjMinute = 1'b1;
        run(hold);
        AdjHour = 1'b0;
        AdjMinute = 1'b0;
        run(3);
    endtask

    initial begin
        int m0, cnt;
        bit found;
        model_reset();
        run(3);
        chk("rst_hour", Hour, 8'h00);
        chk("rst_sec", Second, 8'h00);
        chk("rst_ahour", AHour, 8'h07);
        chk("rst_amin", AMinutes, 8'h00);
        chk("rst_ring", AlarmRing, 0);
        Reset = 1'b0;
        for (int n = 1; n <= 243; n++) begin
            tick_cmp();
            if (n == 239) begin
                chk("c239_sec", Second, 8'h59);
                chk("c239_min", Minutes, 8'h00);
            end
            if (n == 240) begin
                chk("c240_sec", Second, 8'h00);
                chk("c240_min", Minutes, 8'h01);
            end
        end

        Mode = 2'd1;
        run(2);
        for (int i = 0; i < 30 && (m_tod / 3600) != 23; i++)
            press(1'b1, $urandom_range(1, 3));
        for (int i = 0; i < 70 && ((m_tod / 60) % 60) != 59; i++)
            press(1'b0, $urandom_range(1, 3));
        chk("set_hour", Hour, 8'h23);
        chk("set_min", Minutes, 8'h59);
        chk("set_sec", Second, 8'h00);
        Mode = 2'd0;
        for (int n = 1; n <= 262; n++) begin
            tick_cmp();
            if (n == 236) chk("pre_sec", Second, 8'h59);
            if (n == 240) begin
                chk("wrap_hour", Hour, 8'h00);
                chk("wrap_min", Minutes, 8'h00);
                chk("wrap_sec", Second, 8'h00);
                chk("chime_240", HourChime, 0);
            end
            if (n == 241) chk("chime_241", HourChime, 1);
            if (n == 260) chk("chime_260", HourChime, 1);
            if (n == 261) chk("chime_261", HourChime, 0);
        end

        Mode = 2'd2;
        for (int i = 0; i < 30 && (m_ahm / 60) != 0; i++)
            press(1'b1, $urandom_range(1, 3));
        for (int i = 0; i < 70 && (m_ahm % 60) != 2; i++)
            press(1'b0, $urandom_range(1, 3));
        chk("al_hour", AHour, 8'h00);
        chk("al_min", AMinutes, 8'h02);
        AlarmEn = 1'b1;
        Mode = 2'd0;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick_cmp();
            if (Minutes === 8'h02) found = 1;
        end
        chk("alarm_reached", found, 1);
        cnt = 0;
        for (int i = 0; i < 301; i++) begin
            tick_cmp();
            if (AlarmRing === 1'b1) cnt++;
        end
        chk("ring_len", cnt, 240);
        Mode = 2'd2;
        press(1'b0, 1);
        Mode = 2'd0;
        run(8);
        chk("ring_on", AlarmRing, 1);
        AlarmEn = 1'b0;
        tick_cmp();
        chk("ring_drop", AlarmRing, 0);

        Mode = 2'd1;
        run(4);
        m0 = (m_tod / 60) % 60;
        AdjMinute = 1'b1;
        run(2);
        chk("hold_e2", Minutes, bcd(m0));
        tick_cmp();
        chk("hold_e3", Minutes, bcd((m0 + 1) % 60));
        run(97);
        chk("hold_e100", Minutes, bcd((m0 + 1) % 60));
        AdjMinute = 1'b0;
        run(4);
        chk("hold_rel", Minutes, bcd((m0 + 1) % 60));

        for (int seg = 0; seg < 40; seg++) begin
            Mode = 2'($urandom_range(0, 3));
            AlarmEn = 1'($urandom_range(0, 1));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 3) == 0) AdjHour = ~AdjHour;
                if ($urandom_range(0, 3) == 0) AdjMinute = ~AdjMinute;
                tick_cmp();
            end
        end
        AdjHour = 1'b0;
        AdjMinute = 1'b0;

        Mode = 2'd1;
        run(4);
        for (int i = 0; i < 30 && (m_tod / 3600) != 12; i++)
            press(1'b1, 1);
        for (int i = 0; i < 70 && ((m_tod / 60) % 60) != 34; i++)
            press(1'b0, 1);
        Mode = 2'd0;
        run(56 * T + 2);
        chk("pre_rst_hour", Hour, 8'h12);
        chk("pre_rst_min", Minutes, 8'h34);
        chk("pre_rst_sec", Second, 8'h56);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("arst_hour", Hour, 8'h00);
        chk("arst_min", Minutes, 8'h00);
        chk("arst_sec", Second, 8'h00);
        chk("arst_ahour", AHour, 8'h07);
        chk("arst_amin", AMinutes, 8'h00);
        chk("arst_ring", AlarmRing, 0);
        chk("arst_chime", HourChime, 0);
        run(2);
        Reset = 1'b0;
        run(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
